shift_harness_ser: RTL
======================

// Module: shift_harness_ser
// PURPOSE
//  Parametrised bit-serial test harness for the combinational compressor under test.
//  Loads NCH operand channels of W bits each from NCH serial pins, presents them on op_bus,
//  captures the DW-bit result from res_bus, and shifts it out on one serial pin.
//  Successor to the fixed 9x9 harness: width and channel count are generic, load is
//  start-triggered and bounded, and output is serialised so any DW fits in few pins.
// PARAMETERS
//  NCH  9   number of operand channels (>=1)
//  W    9   bits per channel (>=2)
//  DW   13  compressor result width (>=1)
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      begin a load/evaluate/drain cycle; sampled only in IDLE
//  sin      in   NCH    serial operand bits, sin[i] feeds channel i
//  op_bus   out  NCH*W  operand registers; channel i = op_bus[i*W +: W]
//  res_bus  in   DW     compressor result, combinational from op_bus
//  sout     out  1      serial result bit, LSB first
//  sout_vld out  1      high while sout carries a valid result bit
//  busy     out  1      high in any state other than IDLE
//  done     out  1      one-cycle pulse after the last result bit
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; op regs, capture reg, bit counter = 0;
//   sout=0, sout_vld=0, busy=0, done=0. Takes effect immediately, including mid-operation.
//  FSM states and transitions:
//   IDLE  -> FILL when start=1; counter cleared
//   FILL  -> EVAL after exactly W shift edges
//   EVAL  -> DRAIN on one edge, which captures res_bus into cap[DW-1:0]
//   DRAIN -> DONE after DW bits
//   DONE  -> IDLE unconditionally
//  FILL: every edge, ch[i] <= {ch[i][W-2:0], sin[i]}, so bit 0 holds the newest bit.
//   After W edges, the first bit driven is in bit W-1.
//  op_bus is always driven straight from the registers.
//   Registers hold in IDLE/EVAL/DRAIN/DONE; they are not cleared by a new start
//   (they are fully overwritten by W shifts).
//  EVAL: one full settle cycle for the combinational compressor; no shift.
//  DRAIN: sout=cap[0] and sout_vld=1 in the first DRAIN cycle; cap shifts right each edge.
//   Bit k appears in DRAIN cycle k, for k=0..DW-1.
//  sout and sout_vld are registered outputs; sout=0 whenever sout_vld=0.
//  done=1 only in the DONE cycle; busy=0 in IDLE only.
//  Latency: start high at edge t -> FILL shifts at edges t+1..t+W; capture at edge t+W+1;
//   sout_vld high for cycles t+W+2..t+W+DW+1; done high in cycle t+W+DW+2.
//  start outside IDLE, including in DONE, is ignored with no queuing.
//   Back-to-back runs need start in the first IDLE cycle.
//  Counter width is clog2(max(W,DW)+1); there is no wrap within a run.
//  res_bus changes after capture do not affect sout.
//  NCH=1 and DW=1 are legal and need no special casing.
// TESTING
//  1 Reset: assert rst_n=0 mid-DRAIN -> same cycle busy=0, sout_vld=0, sout=0,
//    op_bus=0; after release, idle until start.
//  2 Fill pattern (NCH=9,W=9): sin=9'h1FF for all 9 FILL cycles
//    -> op_bus = 81'h1_FFFF_FFFF_FFFF_FFFF_FFFF.
//  3 Ordering: ch0 driven 1,0,0,0,0,0,0,0,0; other channels 0
//    -> op_bus[8:0]=9'h100, every other channel=0.
//  4 Drain: res_bus=13'h1A5B, then change res_bus after capture
//    -> sout over 13 vld cycles = 1,1,0,1,1,0,1,0,0,1,0,1,1; done at start+W+DW+2 = cycle 24.
//  5 Ignored start: pulse start during FILL, DRAIN and DONE
//    -> no restart, timing identical to test 4; start in the next IDLE launches a new run.
//  6 Generic: NCH=3,W=4,DW=5, res_bus=5'h11
//    -> sout 1,0,0,0,1; done 11 cycles after start.

Source files
------------

// File: rtl/shift_harness_ser.sv
// Bit-serial harness around a combinational compressor: shifts NCH operand channels in,
// gives the compressor one settle cycle, captures its DW-bit result and shifts it out LSB first.
module shift_harness_ser #(
    parameter int unsigned NCH = 9,
    parameter int unsigned W   = 9,
    parameter int unsigned DW  = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NCH-1:0]   sin,
    output logic [NCH*W-1:0] op_bus,
    input  logic [DW-1:0]    res_bus,
    output logic             sout,
    output logic             sout_vld,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MaxLen = (W > DW) ? W : DW;
    localparam int unsigned CW     = $clog2(MaxLen + 1);

    localparam logic [CW-1:0] FillLast  = CW'(W - 1);
    localparam logic [CW-1:0] DrainLast = CW'(DW - 1);
    localparam logic [CW-1:0] CntOne    = CW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StEval,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [NCH*W-1:0] op_q, op_d;
    logic [DW-1:0]    cap_q, cap_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             vld_q, vld_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        sout_d  = 1'b0;
        vld_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFill;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                // Newest bit enters at bit 0, so the first bit ends up in bit W-1.
                for (int i = 0; i < NCH; i++) begin
                    op_d[i*W +: W] = {op_q[i*W +: W-1], sin[i]};
                end
                if (cnt_q == FillLast) begin
                    state_d = StEval;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StEval: begin
                cap_d   = res_bus;
                sout_d  = res_bus[0];
                vld_d   = 1'b1;
                cnt_d   = '0;
                state_d = StDrain;
            end
            StDrain: begin
                // Rotate right: the next bit lands in cap[0]; wrapped bits are never emitted.
                cap_d = (cap_q >> 1) | (cap_q << (DW - 1));
                if (cnt_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d  = cnt_q + CntOne;
                    sout_d = cap_d[0];
                    vld_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            vld_q   <= vld_d;
        end
    end

    assign op_bus   = op_q;
    assign sout     = sout_q;
    assign sout_vld = vld_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

endmodule
